dmem_req_ctrl: RTL and testbench

Memory-stage initiator for the Y86-64 datapath. It turns the memory-stage operands (icode, valE, valA, valP) into one request on a req/ack data-memory port. It then holds the request until the memory responds, captures read data into valM, and reports dmem_error for the STAT logic. It replaces the single-cycle combinational memory access, so the memory itself can take several cycles.

---
 rtl/dmem_req_ctrl_if.sv | 13 +
 rtl/dmem_req_ctrl.sv | 118 +++++++++++
 tb/tb_dmem_req_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_req_ctrl_if.sv
// Req/ack data-memory port between the memory-stage initiator (master) and data memory (slave).
interface dmem_req_ctrl_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_req_ctrl.sv
// Y86-64 memory-stage initiator: one req/ack access per start, with timeout and error status.
// Optional: define DMEM_ALIGN_CHECK_EN to reject addresses with addr[2:0] != 0.
module dmem_req_ctrl #(
  parameter logic [63:0] ADDR_LIMIT = 64'd258,
  parameter int          TIMEOUT    = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             icode,
  input  logic [63:0]            valE,
  input  logic [63:0]            valA,
  input  logic [63:0]            valP,
  dmem_req_ctrl_if.master        mem,
  output logic                   busy,
  output logic                   done,
  output logic [63:0]            valM,
  output logic                   dmem_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q;
  logic        req_q, we_q, err_q;
  logic [63:0] addr_q, wdata_q, valm_q;
  logic [7:0]  cnt_q;

  logic        is_mem_d, we_d, bad_addr_d;
  logic [63:0] addr_d, wdata_d;

  always_comb begin
    is_mem_d = 1'b1;
    we_d     = 1'b0;
    addr_d   = valE;
    wdata_d  = valA;
    case (icode)
      4'h4, 4'hA: we_d = 1'b1;
      4'h8: begin
        we_d    = 1'b1;
        wdata_d = valP;
      end
      4'h5: ;
      4'h9, 4'hB: addr_d = valA;
      default: is_mem_d = 1'b0;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    bad_addr_d = (addr_d >= ADDR_LIMIT) || (addr_d[2:0] != 3'd0);
`else
    bad_addr_d = (addr_d >= ADDR_LIMIT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valm_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            err_q <= 1'b0;
            cnt_q <= '0;
            if (!is_mem_d) begin
              state_q <= FIN;
            end else if (bad_addr_d) begin
              err_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              req_q   <= 1'b1;
              we_q    <= we_d;
              addr_q  <= addr_d;
              wdata_q <= wdata_d;
              state_q <= REQ;
            end
          end
        end
        REQ, RESP: begin
          // ack takes priority over a timeout expiring in the same cycle
          if (mem.ack) begin
            req_q   <= 1'b0;
            err_q   <= mem.err;
            if (!we_q) valm_q <= mem.rdata;
            state_q <= FIN;
          end else if (cnt_q == CNT_LAST) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= FIN;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.req    = req_q;
  assign mem.we     = we_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign busy       = (state_q == REQ) || (state_q == RESP);
  assign done       = (state_q == FIN);
  assign valM       = valm_q;
  assign dmem_error = err_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: writes, reads, range/timeout errors, ignored inputs, reset.
module tb_dmem_req_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        busy, done, dmem_error;
  logic [63:0] valM;
  int          checks = 0;
  int          errors = 0;
  int          n;

  dmem_req_ctrl_if m ();

  dmem_req_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP), .mem(m.master),
    .busy(busy), .done(done), .valM(valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    start = 1'b1; icode = ic; valE = e; valA = a; valP = p;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
    m.ack = 1'b0; m.rdata = '0; m.err = 1'b0;
    step(); step();
    chk("rst_req", m.req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", dmem_error, 0);
    chk("rst_addr", m.addr, 0);
    chk("rst_valM", valM, 0);
    rst_n = 1'b1;
    step();

    // 1: write, ack in the third request cycle
    issue(4'h4, 64'h10, 64'hDEAD, 64'h99);
    chk("w_req1", m.req, 1);
    chk("w_addr", m.addr, 64'h10);
    chk("w_we", m.we, 1);
    chk("w_wdata", m.wdata, 64'hDEAD);
    chk("w_busy", busy, 1);
    step();
    chk("w_req2", m.req, 1);
    step();
    chk("w_req3", m.req, 1);
    chk("w_addr3", m.addr, 64'h10);
    m.ack = 1'b1; m.rdata = 64'hBAD;
    step();
    m.ack = 1'b0;
    chk("w_req_drop", m.req, 0);
    chk("w_done", done, 1);
    chk("w_busy_done", busy, 0);
    chk("w_err", dmem_error, 0);
    chk("w_valM", valM, 0);
    step();
    chk("w_done_1cyc", done, 0);

    // 2: read with ack in first request cycle, address from valA
    issue(4'hB, 64'h999, 64'h20, 64'h0);
    chk("r_req", m.req, 1);
    chk("r_we", m.we, 0);
    chk("r_addr", m.addr, 64'h20);
    m.ack = 1'b1; m.rdata = 64'h1234;
    step();
    m.ack = 1'b0;
    chk("r_done", done, 1);
    chk("r_valM", valM, 64'h1234);
    chk("r_req_drop", m.req, 0);
    step();

    // 3: range boundary
    issue(4'h5, 64'd258, 64'h0, 64'h0);
    chk("oor_req", m.req, 0);
    chk("oor_done", done, 1);
    chk("oor_err", dmem_error, 1);
    step();
    chk("oor_err_hold", dmem_error, 1);
    chk("oor_done_low", done, 0);
    issue(4'h5, 64'd257, 64'h0, 64'h0);
    chk("lim_req", m.req, 1);
    chk("lim_addr", m.addr, 64'd257);
    chk("lim_err_clr", dmem_error, 0);
    m.ack = 1'b1; m.rdata = 64'h55;
    step();
    m.ack = 1'b0;
    chk("lim_done", done, 1);
    chk("lim_valM", valM, 64'h55);
    step();

    // call-style write of valP, memory reports a fault
    issue(4'h8, 64'h40, 64'h11, 64'h77);
    chk("c_wdata", m.wdata, 64'h77);
    chk("c_addr", m.addr, 64'h40);
    m.ack = 1'b1; m.err = 1'b1; m.rdata = 64'hEEEE;
    step();
    m.ack = 1'b0; m.err = 1'b0;
    chk("c_err", dmem_error, 1);
    chk("c_valM", valM, 64'h55);
    step();

    // 4: timeout, then a late ack in IDLE
    issue(4'h9, 64'h0, 64'h30, 64'h0);
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (m.req) n++;
      step();
    end
    chk("to_done", done, 1);
    chk("to_req_cycles", n, 15);
    chk("to_err", dmem_error, 1);
    chk("to_valM", valM, 64'h55);
    step();
    m.ack = 1'b1; m.rdata = 64'hFFFF;
    step();
    m.ack = 1'b0;
    chk("late_done", done, 0);
    chk("late_valM", valM, 64'h55);
    chk("late_req", m.req, 0);

    // ack in the 15th waiting cycle still completes normally
    issue(4'h5, 64'h8, 64'h0, 64'h0);
    for (int i = 0; i < 14; i++) step();
    chk("edge_req", m.req, 1);
    m.ack = 1'b1; m.rdata = 64'h4242;
    step();
    m.ack = 1'b0;
    chk("edge_done", done, 1);
    chk("edge_err", dmem_error, 0);
    chk("edge_valM", valM, 64'h4242);
    step();

    // 5: non-memory icode, then start while busy is ignored
    issue(4'h6, 64'h1000, 64'h0, 64'h0);
    chk("nop_req", m.req, 0);
    chk("nop_done", done, 1);
    chk("nop_err", dmem_error, 0);
    step();
    issue(4'h5, 64'h18, 64'h0, 64'h0);
    issue(4'h4, 64'h28, 64'h1, 64'h0);
    chk("bz_addr", m.addr, 64'h18);
    chk("bz_we", m.we, 0);
    m.ack = 1'b1; m.rdata = 64'hAB;
    step();
    m.ack = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) n++;
      step();
    end
    chk("bz_single_done", n, 1);
    chk("bz_valM", valM, 64'hAB);
    chk("bz_no_req", m.req, 0);

    // 6: asynchronous reset mid-request
    issue(4'h5, 64'h8, 64'h0, 64'h0);
    chk("mr_req", m.req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req_drop", m.req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_valM", valM, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) n++;
    end
    rst_n = 1'b1;
    step();
    if (done) n++;
    chk("mr_no_done", n, 0);

`ifdef DMEM_ALIGN_CHECK_EN
    issue(4'h5, 64'h13, 64'h0, 64'h0);
    chk("al_req", m.req, 0);
    chk("al_done", done, 1);
    chk("al_err", dmem_error, 1);
    step();
`else
    issue(4'h5, 64'h13, 64'h0, 64'h0);
    chk("al_req", m.req, 1);
    chk("al_addr", m.addr, 64'h13);
    m.ack = 1'b1; m.rdata = 64'h31;
    step();
    m.ack = 1'b0;
    chk("al_err", dmem_error, 0);
    chk("al_valM", valM, 64'h31);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
